// File: rtl/csr_exec_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csr_exec_unit_pkg
// Description : Shared function-unit opcode type for the CSR execution path.
// Revision    : 1.0 - initial release
// ============================================================================
package csr_exec_unit_pkg;

    typedef enum logic [1:0] {
        CSR_READ  = 2'd0,
        CSR_WRITE = 2'd1,
        CSR_SET   = 2'd2,
        CSR_CLEAR = 2'd3
    } fu_op_e;

endpackage
`default_nettype wire

// File: rtl/csr_exec_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : csr_exec_unit_if
// Description : Issue, ROB-head, CSR-file, writeback and redirect signals.
// Revision    : 1.0 - initial release
// ============================================================================
interface csr_exec_unit_if
    import csr_exec_unit_pkg::*;
#(
    parameter int TAG_W = 4
) ();

    logic             req_valid;
    logic             req_ready;
    fu_op_e           req_op;
    logic             req_ecall;
    logic             req_mret;
    logic             req_nowrite;
    logic [11:0]      req_addr;
    logic [31:0]      req_operand;
    logic [31:0]      req_pc;
    logic [TAG_W-1:0] req_tag;
    logic             rob_head_valid;
    logic [TAG_W-1:0] rob_head_tag;
    logic             flush;
    fu_op_e           csr_op;
    logic [11:0]      csr_addr;
    logic [31:0]      csr_wdata;
    logic [31:0]      csr_pc;
    logic             ecall;
    logic             mret;
    logic [31:0]      csr_rdata;
    logic [31:0]      mtvec_addr;
    logic [31:0]      mepc_addr;
    logic             wb_valid;
    logic             wb_ready;
    logic [TAG_W-1:0] wb_tag;
    logic [31:0]      wb_data;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;

    // The execution unit itself
    modport slave (
        input  req_valid, req_op, req_ecall, req_mret, req_nowrite,
               req_addr, req_operand, req_pc, req_tag,
               rob_head_valid, rob_head_tag, flush,
               csr_rdata, mtvec_addr, mepc_addr, wb_ready,
        output req_ready, csr_op, csr_addr, csr_wdata, csr_pc, ecall, mret,
               wb_valid, wb_tag, wb_data, redirect_valid, redirect_pc
    );

    // Issue queue, ROB, CSR register file and writeback bus
    modport master (
        output req_valid, req_op, req_ecall, req_mret, req_nowrite,
               req_addr, req_operand, req_pc, req_tag,
               rob_head_valid, rob_head_tag, flush,
               csr_rdata, mtvec_addr, mepc_addr, wb_ready,
        input  req_ready, csr_op, csr_addr, csr_wdata, csr_pc, ecall, mret,
               wb_valid, wb_tag, wb_data, redirect_valid, redirect_pc
    );

endinterface
`default_nettype wire

// File: rtl/csr_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : csr_exec_unit
// Description : Single-entry CSR/ECALL/MRET executor serialised to ROB head.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_exec_unit
    import csr_exec_unit_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  wire logic       clock,
    input  wire logic       reset,
    csr_exec_unit_if.slave  bus
);

    localparam logic [1:0] c_st_idle      = 2'd0;
    localparam logic [1:0] c_st_wait_head = 2'd1;
    localparam logic [1:0] c_st_exec      = 2'd2;
    localparam logic [1:0] c_st_wb        = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    fu_op_e           r_op;
    logic             r_ecall;
    logic             r_mret;
    logic             r_nowrite;
    logic [11:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_pc;
    logic [TAG_W-1:0] r_tag;
    logic [31:0]      r_wb_data;
    logic [31:0]      r_redirect_pc;
    logic             r_first_wb;
    logic             w_accept;
    logic             w_head_match;

    assign w_accept     = (r_state == c_st_idle) && bus.req_valid && !bus.flush;
    assign w_head_match = bus.rob_head_valid && (bus.rob_head_tag == r_tag);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle:      if (w_accept) w_next_state = c_st_wait_head;
            // Flush wins over a same-cycle head match
            c_st_wait_head: if (bus.flush) w_next_state = c_st_idle;
                            else if (w_head_match) w_next_state = c_st_exec;
            c_st_exec:      w_next_state = c_st_wb;
            c_st_wb:        if (bus.wb_ready) w_next_state = c_st_idle;
            default:        w_next_state = c_st_idle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_op          <= CSR_READ;
            r_ecall       <= 1'b0;
            r_mret        <= 1'b0;
            r_nowrite     <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_pc          <= '0;
            r_tag         <= '0;
            r_wb_data     <= '0;
            r_redirect_pc <= '0;
            r_first_wb    <= 1'b0;
        end else begin
            r_first_wb <= (r_state == c_st_exec);
            if (w_accept) begin
                r_op      <= bus.req_op;
                r_ecall   <= bus.req_ecall;
                r_mret    <= bus.req_mret;
                r_nowrite <= bus.req_nowrite;
                r_addr    <= bus.req_addr;
                r_wdata   <= bus.req_operand;
                r_pc      <= bus.req_pc;
                r_tag     <= bus.req_tag;
            end
            if (r_state == c_st_exec) begin
                r_wb_data     <= (r_ecall || r_mret) ? 32'd0 : bus.csr_rdata;
                r_redirect_pc <= r_ecall ? bus.mtvec_addr :
                                 (r_mret ? bus.mepc_addr : 32'd0);
            end
        end
    end

    // Outputs are masked during reset so they read as idle in the reset cycle itself
    always_comb begin
        bus.req_ready      = (r_state == c_st_idle) && !reset;
        bus.csr_op         = CSR_READ;
        bus.ecall          = 1'b0;
        bus.mret           = 1'b0;
        bus.wb_valid       = (r_state == c_st_wb) && !reset;
        bus.redirect_valid = (r_state == c_st_wb) && r_first_wb &&
                             (r_ecall || r_mret) && !reset;
        if ((r_state == c_st_exec) && !reset) begin
            bus.csr_op = (r_nowrite || r_ecall || r_mret) ? CSR_READ : r_op;
            bus.ecall  = r_ecall;
            bus.mret   = r_mret;
        end
        bus.csr_addr    = reset ? 12'd0 : r_addr;
        bus.csr_wdata   = reset ? 32'd0 : r_wdata;
        bus.csr_pc      = reset ? 32'd0 : r_pc;
        bus.wb_tag      = reset ? '0 : r_tag;
        bus.wb_data     = reset ? 32'd0 : r_wb_data;
        bus.redirect_pc = reset ? 32'd0 : r_redirect_pc;
    end

endmodule
`default_nettype wire

// File: tb/tb_csr_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_exec_unit
// Description : Directed self-checking bench with a small CSR register file.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_exec_unit;
    import csr_exec_unit_pkg::*;

    logic clock;
    logic reset;
    int   n_vec;
    int   n_err;

    csr_exec_unit_if #(.TAG_W(4)) bus ();

    csr_exec_unit #(.TAG_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Minimal machine-mode CSR file: mstatus, mtvec, mepc
    logic [31:0] m_mstatus;
    logic [31:0] m_mtvec;
    logic [31:0] m_mepc;

    function automatic logic [31:0] apply_op(fu_op_e op, logic [31:0] old, logic [31:0] w);
        case (op)
            CSR_WRITE: return w;
            CSR_SET:   return old | w;
            CSR_CLEAR: return old & ~w;
            default:   return old;
        endcase
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            m_mstatus <= 32'h0000_1800;
            m_mtvec   <= 32'd0;
            m_mepc    <= 32'd0;
        end else begin
            if (bus.ecall) m_mepc <= bus.csr_pc;
            case (bus.csr_addr)
                12'h300: m_mstatus <= apply_op(bus.csr_op, m_mstatus, bus.csr_wdata);
                12'h305: m_mtvec   <= apply_op(bus.csr_op, m_mtvec, bus.csr_wdata);
                12'h341: if (!bus.ecall) m_mepc <= apply_op(bus.csr_op, m_mepc, bus.csr_wdata);
                default: ;
            endcase
        end
    end

    always_comb begin
        case (bus.csr_addr)
            12'h300: bus.csr_rdata = m_mstatus;
            12'h305: bus.csr_rdata = m_mtvec;
            12'h341: bus.csr_rdata = m_mepc;
            default: bus.csr_rdata = 32'd0;
        endcase
    end
    assign bus.mtvec_addr = m_mtvec;
    assign bus.mepc_addr  = m_mepc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input fu_op_e op, input logic ec, input logic mr, input logic nw,
                         input logic [11:0] addr, input logic [31:0] opnd,
                         input logic [31:0] pc, input logic [3:0] tag);
        bus.req_valid   = 1'b1;
        bus.req_op      = op;
        bus.req_ecall   = ec;
        bus.req_mret    = mr;
        bus.req_nowrite = nw;
        bus.req_addr    = addr;
        bus.req_operand = opnd;
        bus.req_pc      = pc;
        bus.req_tag     = tag;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        bus.req_valid      = 1'b0;
        bus.req_op         = CSR_READ;
        bus.req_ecall      = 1'b0;
        bus.req_mret       = 1'b0;
        bus.req_nowrite    = 1'b0;
        bus.req_addr       = 12'd0;
        bus.req_operand    = 32'd0;
        bus.req_pc         = 32'd0;
        bus.req_tag        = 4'd0;
        bus.rob_head_valid = 1'b0;
        bus.rob_head_tag   = 4'd0;
        bus.flush          = 1'b0;
        bus.wb_ready       = 1'b1;

        tick();
        tick();
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        check("rst_csr_op", 32'(bus.csr_op), 32'(CSR_READ));
        check("rst_csr_pc", bus.csr_pc, 32'd0);
        reset = 1'b0;
        tick();
        check("post_rst_ready", 32'(bus.req_ready), 32'd1);

        // CSRRW mtvec, head already matching
        issue(CSR_WRITE, 1'b0, 1'b0, 1'b0, 12'h305, 32'h8000_0100, 32'h8000_0000, 4'd3);
        bus.rob_head_valid = 1'b1;
        bus.rob_head_tag   = 4'd3;
        tick();
        bus.req_valid = 1'b0;
        check("rw_wait_ready", 32'(bus.req_ready), 32'd0);
        check("rw_wait_op", 32'(bus.csr_op), 32'(CSR_READ));
        tick();
        check("rw_exec_op", 32'(bus.csr_op), 32'(CSR_WRITE));
        check("rw_exec_addr", 32'(bus.csr_addr), 32'h305);
        check("rw_exec_wdata", bus.csr_wdata, 32'h8000_0100);
        tick();
        check("rw_wb_valid", 32'(bus.wb_valid), 32'd1);
        check("rw_wb_data", bus.wb_data, 32'd0);
        check("rw_wb_tag", 32'(bus.wb_tag), 32'd3);
        check("rw_no_redirect", 32'(bus.redirect_valid), 32'd0);
        check("rw_mtvec", m_mtvec, 32'h8000_0100);
        tick();
        check("rw_idle", 32'(bus.req_ready), 32'd1);

        // CSRRS mstatus, read-only form
        issue(CSR_SET, 1'b0, 1'b0, 1'b1, 12'h300, 32'h0000_0008, 32'h8000_0004, 4'd4);
        bus.rob_head_tag = 4'd4;
        tick();
        bus.req_valid = 1'b0;
        tick();
        check("ro_exec_op", 32'(bus.csr_op), 32'(CSR_READ));
        tick();
        check("ro_wb_data", bus.wb_data, 32'h0000_1800);
        check("ro_mstatus", m_mstatus, 32'h0000_1800);
        tick();

        // Tag 5 waits behind head 2 for 10 cycles
        bus.rob_head_tag = 4'd2;
        issue(CSR_SET, 1'b0, 1'b0, 1'b0, 12'h300, 32'h0000_0008, 32'h8000_0008, 4'd5);
        tick();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("wait_op", 32'(bus.csr_op), 32'(CSR_READ));
            tick();
        end
        check("wait_no_wb", 32'(bus.wb_valid), 32'd0);
        bus.rob_head_tag = 4'd5;
        check("wait_match_op", 32'(bus.csr_op), 32'(CSR_READ));
        tick();
        check("wait_exec_op", 32'(bus.csr_op), 32'(CSR_SET));
        check("wait_exec_wdata", bus.csr_wdata, 32'h0000_0008);
        tick();
        check("wait_wb_data", bus.wb_data, 32'h0000_1800);
        check("wait_mstatus", m_mstatus, 32'h0000_1808);
        tick();

        // Flush in WAIT_HEAD, coinciding with a head match
        bus.rob_head_tag = 4'd2;
        issue(CSR_CLEAR, 1'b0, 1'b0, 1'b0, 12'h300, 32'h0000_1808, 32'h8000_000c, 4'd5);
        tick();
        bus.req_valid = 1'b0;
        tick();
        bus.flush        = 1'b1;
        bus.rob_head_tag = 4'd5;
        tick();
        bus.flush = 1'b0;
        check("flush_ready", 32'(bus.req_ready), 32'd1);
        check("flush_op", 32'(bus.csr_op), 32'(CSR_READ));
        tick();
        tick();
        check("flush_mstatus", m_mstatus, 32'h0000_1808);
        check("flush_no_wb", 32'(bus.wb_valid), 32'd0);

        // Request blocked by flush in IDLE
        issue(CSR_CLEAR, 1'b0, 1'b0, 1'b0, 12'h300, 32'h0000_1808, 32'h8000_000c, 4'd5);
        bus.flush = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        check("idle_flush_ready", 32'(bus.req_ready), 32'd1);
        tick();
        check("idle_flush_op", 32'(bus.csr_op), 32'(CSR_READ));

        // ECALL
        issue(CSR_WRITE, 1'b1, 1'b0, 1'b0, 12'h305, 32'hdead_beef, 32'h8000_0010, 4'd6);
        bus.rob_head_tag = 4'd6;
        tick();
        bus.req_valid = 1'b0;
        check("ecall_pc", bus.csr_pc, 32'h8000_0010);
        check("ecall_wait_strobe", 32'(bus.ecall), 32'd0);
        tick();
        check("ecall_strobe", 32'(bus.ecall), 32'd1);
        check("ecall_op", 32'(bus.csr_op), 32'(CSR_READ));
        tick();
        check("ecall_strobe_end", 32'(bus.ecall), 32'd0);
        check("ecall_redirect", 32'(bus.redirect_valid), 32'd1);
        check("ecall_redirect_pc", bus.redirect_pc, 32'h8000_0100);
        check("ecall_wb_data", bus.wb_data, 32'd0);
        check("ecall_wb_tag", 32'(bus.wb_tag), 32'd6);
        check("ecall_mepc", m_mepc, 32'h8000_0010);
        check("ecall_mtvec", m_mtvec, 32'h8000_0100);
        tick();
        check("ecall_redirect_end", 32'(bus.redirect_valid), 32'd0);

        // MRET with a stalled writeback, then reset mid-WB
        bus.wb_ready = 1'b0;
        issue(CSR_SET, 1'b0, 1'b1, 1'b0, 12'h300, 32'h0000_ffff, 32'h8000_0020, 4'd7);
        bus.rob_head_tag = 4'd7;
        tick();
        bus.req_valid = 1'b0;
        tick();
        check("mret_strobe", 32'(bus.mret), 32'd1);
        check("mret_op", 32'(bus.csr_op), 32'(CSR_READ));
        tick();
        check("mret_strobe_end", 32'(bus.mret), 32'd0);
        check("mret_redirect", 32'(bus.redirect_valid), 32'd1);
        check("mret_redirect_pc", bus.redirect_pc, 32'h8000_0010);
        check("mret_wb_valid", 32'(bus.wb_valid), 32'd1);
        check("mret_wb_data", bus.wb_data, 32'd0);
        check("mret_mstatus", m_mstatus, 32'h0000_1808);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mret_hold_valid", 32'(bus.wb_valid), 32'd1);
            check("mret_hold_redirect", 32'(bus.redirect_valid), 32'd0);
            check("mret_hold_tag", 32'(bus.wb_tag), 32'd7);
        end
        reset = 1'b1;
        #1;
        check("mid_rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        check("mid_rst_ready", 32'(bus.req_ready), 32'd0);
        check("mid_rst_wb_tag", 32'(bus.wb_tag), 32'd0);
        check("mid_rst_csr_pc", bus.csr_pc, 32'd0);
        tick();
        check("mid_rst_wb_valid2", 32'(bus.wb_valid), 32'd0);
        check("mid_rst_csr_addr", 32'(bus.csr_addr), 32'd0);
        reset        = 1'b0;
        bus.wb_ready = 1'b1;
        tick();
        check("after_rst_ready", 32'(bus.req_ready), 32'd1);
        check("after_rst_csr_pc", bus.csr_pc, 32'd0);
        check("after_rst_wb_data", bus.wb_data, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
